// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit processor control path.
// Contents:
//   - opcode constants (IR upper nibble)
//   - control-word width and bit index constants
//   - step_t : T-state enum T0..T4 (3 bits)
//   - state_t: sequencer run state IDLE/RUN/HALT
//   - cw_bit(): one-hot control-word helper
package cpu_isa_pkg;

    localparam int CW_WIDTH = 16;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0101;
    localparam logic [3:0] OP_JZ  = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_PC_INC  = 0;
    localparam int CW_PC_OUT  = 1;
    localparam int CW_PC_LOAD = 2;
    localparam int CW_MAR_IN  = 3;
    localparam int CW_RAM_OUT = 4;
    localparam int CW_RAM_IN  = 5;
    localparam int CW_IR_IN   = 6;
    localparam int CW_IR_OUT  = 7;
    localparam int CW_A_IN    = 8;
    localparam int CW_A_OUT   = 9;
    localparam int CW_B_IN    = 10;
    localparam int CW_ALU_OUT = 11;
    localparam int CW_ALU_SUB = 12;
    localparam int CW_OUT_IN  = 13;
    localparam int CW_HALT    = 14;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [CW_WIDTH-1:0] cw_bit(input int idx);
        logic [CW_WIDTH-1:0] w;
        w = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake/control bundle between the instruction sequencer and its
// surroundings (IR, ALU flags, datapath control).
//   master : drives start/step controls, opcode and zero flag; observes outputs
//   slave  : the sequencer itself
interface control_sequencer_if;
    import cpu_isa_pkg::*;

    logic                ctrl_seq_start;
    logic                ctrl_seq_step_mode;
    logic                ctrl_seq_step_pulse;
    logic [3:0]          ctrl_seq_opcode;
    logic                ctrl_seq_zero_flag;
    logic [CW_WIDTH-1:0] ctrl_seq_word;
    logic [2:0]          ctrl_seq_t;
    logic                ctrl_seq_busy;
    logic                ctrl_seq_halted;
    logic                ctrl_seq_instr_done;

    modport master (
        output ctrl_seq_start, ctrl_seq_step_mode, ctrl_seq_step_pulse,
               ctrl_seq_opcode, ctrl_seq_zero_flag,
        input  ctrl_seq_word, ctrl_seq_t, ctrl_seq_busy, ctrl_seq_halted,
               ctrl_seq_instr_done
    );

    modport slave (
        input  ctrl_seq_start, ctrl_seq_step_mode, ctrl_seq_step_pulse,
               ctrl_seq_opcode, ctrl_seq_zero_flag,
        output ctrl_seq_word, ctrl_seq_t, ctrl_seq_busy, ctrl_seq_halted,
               ctrl_seq_instr_done
    );

endinterface

// File: rtl/control_decoder.sv
// Purely combinational microcode decoder.
// Inputs : step (T-state), opcode (IR upper nibble), zero_flag.
// Outputs: word (ungated control word), last (this step ends the instruction).
// Opcode and zero_flag are only looked at in T2..T4; fetch steps are common.
module control_decoder
    import cpu_isa_pkg::*;
(
    input  step_t               step,
    input  logic [3:0]          opcode,
    input  logic                zero_flag,
    output logic [CW_WIDTH-1:0] word,
    output logic                last
);

    always_comb begin
        word = '0;
        last = 1'b0;
        unique case (step)
            T0: word = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);
            T1: word = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_IN) | cw_bit(CW_PC_INC);
            T2: begin
                unique case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        word = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
                    OP_JMP: begin
                        word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                        last = 1'b1;
                    end
                    OP_JZ: begin
                        if (zero_flag)
                            word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                        last = 1'b1;
                    end
                    OP_OUT: begin
                        word = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_IN);
                        last = 1'b1;
                    end
                    OP_HLT: begin
                        word = cw_bit(CW_HALT);
                        last = 1'b1;
                    end
                    default: last = 1'b1;   // NOP
                endcase
            end
            T3: begin
                unique case (opcode)
                    OP_LDA: begin
                        word = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_IN);
                        last = 1'b1;
                    end
                    OP_ADD, OP_SUB:
                        word = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN);
                    OP_STA: begin
                        word = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
                        last = 1'b1;
                    end
                    // Unreachable for short instructions; terminate safely.
                    default: last = 1'b1;
                endcase
            end
            T4: begin
                last = 1'b1;
                if (opcode == OP_ADD)
                    word = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN);
                else if (opcode == OP_SUB)
                    word = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN) | cw_bit(CW_ALU_SUB);
            end
            default: last = 1'b1;   // illegal step encodings fall back to T0
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction-level controller: owns the run/halt state and the T-state
// counter, and gates the decoded control word so a stalled step never
// loads twice.
// Ports:
//   ctrl_seq_clk : clock, rising edge
//   ctrl_seq_rst : asynchronous active-high reset
//   bus          : control_sequencer_if.slave (start/step controls, opcode,
//                  zero flag in; control word, step, busy, halted,
//                  instr_done out)
// Parameter SINGLE_STEP_EN=0 forces free-run regardless of step_mode.
module control_sequencer
    import cpu_isa_pkg::*;
#(
    parameter bit SINGLE_STEP_EN = 1'b1
) (
    input  logic                  ctrl_seq_clk,
    input  logic                  ctrl_seq_rst,
    control_sequencer_if.slave    bus
);

    state_t              state_reg, state_next;
    step_t               step_reg, step_next;
    logic [CW_WIDTH-1:0] dec_word;
    logic                dec_last;
    logic                step_mode_eff;
    logic                advance;

    control_decoder u_decoder (
        .step      (step_reg),
        .opcode    (bus.ctrl_seq_opcode),
        .zero_flag (bus.ctrl_seq_zero_flag),
        .word      (dec_word),
        .last      (dec_last)
    );

    assign step_mode_eff = SINGLE_STEP_EN & bus.ctrl_seq_step_mode;
    // Only RUN advances, so start+step_pulse in IDLE never moves the step.
    assign advance = (state_reg == ST_RUN) && (!step_mode_eff || bus.ctrl_seq_step_pulse);

    always_ff @(posedge ctrl_seq_clk or posedge ctrl_seq_rst) begin
        if (ctrl_seq_rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= T0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.ctrl_seq_start) begin
                    state_next = ST_RUN;
                    step_next  = T0;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (dec_last) begin
                        step_next = T0;
                        // The halt bit only appears on the HLT T2 step.
                        if (dec_word[CW_HALT])
                            state_next = ST_HALT;
                    end else begin
                        step_next = step_t'(step_reg + 3'd1);
                    end
                end
            end
            ST_HALT: ;
            default: begin
                state_next = ST_IDLE;
                step_next  = T0;
            end
        endcase
    end

    assign bus.ctrl_seq_word       = advance ? dec_word : '0;
    assign bus.ctrl_seq_t          = step_reg;
    assign bus.ctrl_seq_busy       = (state_reg == ST_RUN);
    assign bus.ctrl_seq_halted     = (state_reg == ST_HALT);
    assign bus.ctrl_seq_instr_done = advance && dec_last;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an instruction-table model
// checked every cycle on the falling edge, plus hand-computed literal checks
// in the directed stimulus.
module tb_control_sequencer;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    control_sequencer_if bus();

    control_sequencer #(.SINGLE_STEP_EN(1'b1)) dut (
        .ctrl_seq_clk (clk),
        .ctrl_seq_rst (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", nm, act, exp, $time);
        end
    endtask

    // Number of steps of each instruction.
    function automatic int instr_len(input logic [3:0] op);
        case (op)
            4'h0, 4'h4: return 4;
            4'h1, 4'h2: return 5;
            default:    return 3;
        endcase
    endfunction

    // Control word of step 'pos' of an instruction, straight from the ISA table.
    function automatic logic [15:0] step_word(input logic [3:0] op, input logic z, input int pos);
        logic [15:0] seq [5];
        seq[0] = 16'h000A;
        seq[1] = 16'h0051;
        seq[2] = 16'h0000;
        seq[3] = 16'h0000;
        seq[4] = 16'h0000;
        case (op)
            4'h0: begin seq[2] = 16'h0088; seq[3] = 16'h0110; end
            4'h1: begin seq[2] = 16'h0088; seq[3] = 16'h0410; seq[4] = 16'h0900; end
            4'h2: begin seq[2] = 16'h0088; seq[3] = 16'h0410; seq[4] = 16'h1900; end
            4'h4: begin seq[2] = 16'h0088; seq[3] = 16'h0220; end
            4'h5: seq[2] = 16'h0084;
            4'h6: seq[2] = z ? 16'h0084 : 16'h0000;
            4'hE: seq[2] = 16'h2200;
            4'hF: seq[2] = 16'h4000;
            default: ;
        endcase
        if (pos < 0 || pos > 4) return 16'h0000;
        return seq[pos];
    endfunction

    // Reference model: 0 idle, 1 run, 2 halt; m_pos = step within instruction.
    always @(negedge clk) begin
        static int   m_state = 0;
        static int   m_pos   = 0;
        logic        adv, is_last;
        logic [15:0] e_word;
        if (rst) begin
            m_state = 0;
            m_pos   = 0;
            check("m_rst_word", bus.ctrl_seq_word, 16'h0000);
            check("m_rst_t", 16'(bus.ctrl_seq_t), 16'h0000);
            check("m_rst_busy", 16'(bus.ctrl_seq_busy), 16'h0000);
            check("m_rst_halted", 16'(bus.ctrl_seq_halted), 16'h0000);
        end else begin
            adv     = (m_state == 1) && (!bus.ctrl_seq_step_mode || bus.ctrl_seq_step_pulse);
            is_last = (m_pos == instr_len(bus.ctrl_seq_opcode) - 1);
            e_word  = adv ? step_word(bus.ctrl_seq_opcode, bus.ctrl_seq_zero_flag, m_pos) : 16'h0000;
            check("m_word", bus.ctrl_seq_word, e_word);
            check("m_t", 16'(bus.ctrl_seq_t), (m_state == 1) ? 16'(m_pos) : 16'h0000);
            check("m_busy", 16'(bus.ctrl_seq_busy), 16'(m_state == 1));
            check("m_halted", 16'(bus.ctrl_seq_halted), 16'(m_state == 2));
            check("m_done", 16'(bus.ctrl_seq_instr_done), 16'(adv && is_last));
            if (m_state == 0 && bus.ctrl_seq_start) begin
                m_state = 1;
                m_pos   = 0;
            end else if (adv) begin
                if (is_last) begin
                    m_pos = 0;
                    if (bus.ctrl_seq_opcode == 4'hF) m_state = 2;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    // Called at posedge+1 with inputs already set: checks this cycle's
    // outputs, prints one line, then moves to the next posedge+1.
    task automatic step_chk(input string nm, input logic [15:0] w, input logic [2:0] t, input logic d);
        #1;
        $display("%s: t=%0d word=0x%04h done=%0b busy=%0b halted=%0b", nm,
                 bus.ctrl_seq_t, bus.ctrl_seq_word, bus.ctrl_seq_instr_done,
                 bus.ctrl_seq_busy, bus.ctrl_seq_halted);
        check({nm, "_word"}, bus.ctrl_seq_word, w);
        check({nm, "_t"}, 16'(bus.ctrl_seq_t), 16'(t));
        check({nm, "_done"}, 16'(bus.ctrl_seq_instr_done), 16'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic run_free(input string nm, input logic [3:0] op, input logic z, input logic [15:0] w2);
        bus.ctrl_seq_opcode    = op;
        bus.ctrl_seq_zero_flag = z;
        step_chk({nm, "_t0"}, 16'h000A, 3'd0, 1'b0);
        step_chk({nm, "_t1"}, 16'h0051, 3'd1, 1'b0);
        step_chk({nm, "_t2"}, w2, 3'd2, 1'b1);
    endtask

    initial begin
        int pc_cnt;
        rst                     = 1'b1;
        bus.ctrl_seq_start      = 1'b0;
        bus.ctrl_seq_step_mode  = 1'b0;
        bus.ctrl_seq_step_pulse = 1'b0;
        bus.ctrl_seq_opcode     = 4'h0;
        bus.ctrl_seq_zero_flag  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 16'(bus.ctrl_seq_busy), 16'h0000);
        rst = 1'b0;
        step_chk("idle", 16'h0000, 3'd0, 1'b0);

        // LDA free-run
        bus.ctrl_seq_start = 1'b1;
        step_chk("start", 16'h0000, 3'd0, 1'b0);
        bus.ctrl_seq_start = 1'b0;
        step_chk("lda_t0", 16'h000A, 3'd0, 1'b0);
        step_chk("lda_t1", 16'h0051, 3'd1, 1'b0);
        step_chk("lda_t2", 16'h0088, 3'd2, 1'b0);
        step_chk("lda_t3", 16'h0110, 3'd3, 1'b1);

        // ADD, SUB
        bus.ctrl_seq_opcode = 4'h1;
        step_chk("add_t0", 16'h000A, 3'd0, 1'b0);
        step_chk("add_t1", 16'h0051, 3'd1, 1'b0);
        step_chk("add_t2", 16'h0088, 3'd2, 1'b0);
        step_chk("add_t3", 16'h0410, 3'd3, 1'b0);
        step_chk("add_t4", 16'h0900, 3'd4, 1'b1);
        bus.ctrl_seq_opcode = 4'h2;
        step_chk("sub_t0", 16'h000A, 3'd0, 1'b0);
        step_chk("sub_t1", 16'h0051, 3'd1, 1'b0);
        step_chk("sub_t2", 16'h0088, 3'd2, 1'b0);
        step_chk("sub_t3", 16'h0410, 3'd3, 1'b0);
        step_chk("sub_t4", 16'h1900, 3'd4, 1'b1);

        // STA
        bus.ctrl_seq_opcode = 4'h4;
        step_chk("sta_t0", 16'h000A, 3'd0, 1'b0);
        step_chk("sta_t1", 16'h0051, 3'd1, 1'b0);
        step_chk("sta_t2", 16'h0088, 3'd2, 1'b0);
        step_chk("sta_t3", 16'h0220, 3'd3, 1'b1);

        // Three-step instructions
        run_free("jz0", 4'h6, 1'b0, 16'h0000);
        run_free("jz1", 4'h6, 1'b1, 16'h0084);
        run_free("jmp", 4'h5, 1'b0, 16'h0084);
        run_free("out", 4'hE, 1'b0, 16'h2200);
        run_free("nop", 4'h3, 1'b0, 16'h0000);
        step_chk("after_nop_t0", 16'h000A, 3'd0, 1'b0);
        step_chk("after_nop_t1", 16'h0051, 3'd1, 1'b0);
        step_chk("after_nop_t2", 16'h0000, 3'd2, 1'b1);

        // Step mode: LDA with pulses 3 cycles apart
        bus.ctrl_seq_step_mode = 1'b1;
        bus.ctrl_seq_opcode    = 4'h0;
        pc_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            bus.ctrl_seq_step_pulse = (k % 3 == 0);
            #1;
            $display("step k=%0d pulse=%0b t=%0d word=0x%04h", k,
                     bus.ctrl_seq_step_pulse, bus.ctrl_seq_t, bus.ctrl_seq_word);
            if (bus.ctrl_seq_word[0]) pc_cnt++;
            if (!bus.ctrl_seq_step_pulse) check("stall_word", bus.ctrl_seq_word, 16'h0000);
            @(posedge clk);
            #1;
        end
        bus.ctrl_seq_step_pulse = 1'b0;
        check("step_pc_inc_once", 16'(pc_cnt), 16'd1);
        check("step_t_back_to_0", 16'(bus.ctrl_seq_t), 16'd0);

        // ADD in step mode, then drop step mode at T2
        bus.ctrl_seq_opcode     = 4'h1;
        bus.ctrl_seq_step_pulse = 1'b1;
        step_chk("sadd_t0", 16'h000A, 3'd0, 1'b0);
        bus.ctrl_seq_step_pulse = 1'b0;
        step_chk("sadd_stall", 16'h0000, 3'd1, 1'b0);
        bus.ctrl_seq_step_pulse = 1'b1;
        step_chk("sadd_t1", 16'h0051, 3'd1, 1'b0);
        bus.ctrl_seq_step_pulse = 1'b0;
        bus.ctrl_seq_step_mode  = 1'b0;
        step_chk("free_t2", 16'h0088, 3'd2, 1'b0);
        step_chk("free_t3", 16'h0410, 3'd3, 1'b0);
        step_chk("free_t4", 16'h0900, 3'd4, 1'b1);

        // HLT
        run_free("hlt", 4'hF, 1'b0, 16'h4000);
        bus.ctrl_seq_start = 1'b1;
        #1;
        check("halted_flag", 16'(bus.ctrl_seq_halted), 16'h0001);
        check("halted_busy", 16'(bus.ctrl_seq_busy), 16'h0000);
        step_chk("halted_start", 16'h0000, 3'd0, 1'b0);
        bus.ctrl_seq_start = 1'b0;
        check("halt_stays", 16'(bus.ctrl_seq_halted), 16'h0001);
        step_chk("halted_idle", 16'h0000, 3'd0, 1'b0);

        // Reset out of HALT; start and step_pulse together in IDLE
        rst = 1'b1;
        step_chk("rst_halt", 16'h0000, 3'd0, 1'b0);
        rst = 1'b0;
        bus.ctrl_seq_step_mode  = 1'b1;
        bus.ctrl_seq_start      = 1'b1;
        bus.ctrl_seq_step_pulse = 1'b1;
        step_chk("start_pulse", 16'h0000, 3'd0, 1'b0);
        bus.ctrl_seq_start      = 1'b0;
        bus.ctrl_seq_step_pulse = 1'b0;
        check("run_after_start", 16'(bus.ctrl_seq_busy), 16'h0001);
        step_chk("run_stall_t0", 16'h0000, 3'd0, 1'b0);

        // ADD free-run, reset asserted in T3
        bus.ctrl_seq_step_mode = 1'b0;
        bus.ctrl_seq_opcode    = 4'h1;
        step_chk("radd_t0", 16'h000A, 3'd0, 1'b0);
        step_chk("radd_t1", 16'h0051, 3'd1, 1'b0);
        step_chk("radd_t2", 16'h0088, 3'd2, 1'b0);
        #1;
        check("radd_t3_before", bus.ctrl_seq_word, 16'h0410);
        rst = 1'b1;
        #1;
        check("async_rst_word", bus.ctrl_seq_word, 16'h0000);
        check("async_rst_t", 16'(bus.ctrl_seq_t), 16'h0000);
        check("async_rst_busy", 16'(bus.ctrl_seq_busy), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_chk("post_rst_idle0", 16'h0000, 3'd0, 1'b0);
        check("post_rst_busy", 16'(bus.ctrl_seq_busy), 16'h0000);
        step_chk("post_rst_idle1", 16'h0000, 3'd0, 1'b0);
        bus.ctrl_seq_start = 1'b1;
        step_chk("restart", 16'h0000, 3'd0, 1'b0);
        bus.ctrl_seq_start = 1'b0;
        bus.ctrl_seq_opcode = 4'h0;
        step_chk("re_lda_t0", 16'h000A, 3'd0, 1'b0);
        step_chk("re_lda_t1", 16'h0051, 3'd1, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction-level controller for the 8-bit processor. Owns the T-state step counter and the run/halt state, decodes the IR opcode per step, and drives the 16-bit control word that sequences the PC, MAR, RAM, IR, A, B, ALU and output registers. Supports free-run and single-step modes, and ends each instruction early once its last useful step is done.

## Interface
- SINGLE_STEP_EN, 1: when 0, `ctrl_seq_step_mode` is ignored and the block always free-runs.
- ctrl_seq_clk  in  1  clock; all state changes on the rising edge.
- ctrl_seq_rst  in  1  reset; asynchronous, active-high.
- ctrl_seq_start  in  1  one-cycle start strobe; leaves IDLE.
- ctrl_seq_step_mode  in  1  1 means advance only on `ctrl_seq_step_pulse`.
- ctrl_seq_step_pulse  in  1  one-cycle advance strobe, used in step mode.
- ctrl_seq_opcode  in  4  IR upper nibble; valid from T2.
- ctrl_seq_zero_flag  in  1  ALU zero flag, registered.
- ctrl_seq_word  out  16  control word; bit indices are defined in the package.
- ctrl_seq_t  out  3  current step, T0..T4.
- ctrl_seq_busy  out  1  asserted in RUN.
- ctrl_seq_halted  out  1  asserted in HALT.
- ctrl_seq_instr_done  out  1  asserted during the last step of each instruction.

## Operation
- States: IDLE, RUN, HALT.
  - IDLE → RUN on `start`, with step = T0.
  - RUN → HALT after the HLT T2 step.
  - HALT is left only by reset.
  - `start` is ignored in RUN and HALT.
- Advance condition: RUN && (!step_mode_eff || step_pulse). On an advance, step goes to T0 if the current step is last, otherwise step+1.
- Control word gating:
  - `ctrl_seq_word` is decoded combinationally from the registered state, step, opcode and zero_flag.
  - It is forced to 0 in any cycle without an advance, so a stalled step never loads twice.
  - It is 0 in IDLE and HALT.
- Control word bits:
  - pc_inc 0, pc_out 1, pc_load 2, mar_in 3
  - ram_out 4, ram_in 5, ir_in 6, ir_out 7
  - a_in 8, a_out 9, b_in 10, alu_out 11
  - alu_sub 12, out_in 13, halt 14, bit 15 is always 0.
- Fetch steps (all opcodes):
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_inc.
- Execute steps; "last" marks the final step of each instruction:
  - LDA 0000: T2 ir_out+mar_in; T3 ram_out+a_in, last.
  - ADD 0001: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in, last.
  - SUB 0010: as ADD, with alu_sub also asserted at T4.
  - STA 0100: T2 ir_out+mar_in; T3 a_out+ram_in, last.
  - JMP 0101: T2 ir_out+pc_load, last.
  - JZ 0110: T2 ir_out+pc_load only if zero_flag=1, last in both cases.
  - OUT 1110: T2 a_out+out_in, last.
  - HLT 1111: T2 halt, last; then HALT.
  - Any other opcode is a NOP: T2 asserts nothing, last.
- `instr_done` = advance && last step. It is not asserted on T0/T1.

## Timing
- Reset immediately forces state=IDLE, step=T0 and every output to 0, including mid-instruction.
- RUN is entered on the edge that samples `start`; T0 control is driven in the following cycle.
- Step durations in free-run: one cycle per step.
  - LDA/STA take 4 cycles; ADD/SUB 5; JMP/JZ/OUT/NOP/HLT 3.
- `opcode` and `zero_flag` are sampled only in T2–T4. Their values in T0/T1 are don't-care.
- `start` and `step_pulse` in the same IDLE cycle: start wins, and no advance happens that cycle.
- Clearing `step_mode` mid-instruction resumes free-run from the current step on the next cycle.
- HLT: `halt` bit is high for exactly one cycle; `ctrl_seq_halted` is high from the next cycle on.

## Structure
- `cpu_isa_pkg` holds:
  - opcode localparams;
  - control-word bit index constants and the width 16;
  - the step enum (T0..T4, 3 bits);
  - the state enum (IDLE/RUN/HALT).
- One sub-module, `control_decoder`: purely combinational (step, opcode, zero_flag) → {word, last}. The top level holds the FSM, the step register and the gating.

## Test plan
- Reset, then start, free-run with opcode=0000 (LDA): word sequence 0x000A, 0x0051, 0x0088, 0x0110, then T0; `instr_done` high in cycle 4.
- ADD then SUB: T4 word is 0x0900 for ADD and 0x1900 for SUB; five cycles each; `ctrl_seq_t` runs 0,1,2,3,4,0.
- JZ with zero_flag=0: T2 word is 0x0000. With zero_flag=1: T2 word is 0x0084. Both return to T0 after 3 cycles.
- Step mode, with pulses 3 cycles apart: word is nonzero only in pulse cycles, and pc_inc is seen exactly once per instruction.
- HLT: T2 word is 0x4000; then `halted`=1, `busy`=0, word=0; a further `start` is ignored.
- Reset asserted during ADD T3: outputs are 0 asynchronously; after release, IDLE with t=0 until `start`.
